// File: rtl/fifo_wr_arb_if.sv
// Handshake bundle between two frame requesters, the shared FIFO write port
// and the arbiter status outputs.
interface fifo_wr_arb_if #(
  parameter int B = 8
);
  logic         req0;
  logic [B-1:0] data0;
  logic         last0;
  logic         ack0;
  logic         req1;
  logic [B-1:0] data1;
  logic         last1;
  logic         ack1;
  logic         fifo_full;
  logic         fifo_wr;
  logic [B-1:0] fifo_wdata;
  logic         busy;
  logic         owner;
  logic         ovf;

  modport slave (
    input  req0, data0, last0, req1, data1, last1, fifo_full,
    output ack0, ack1, fifo_wr, fifo_wdata, busy, owner, ovf
  );

  modport master (
    output req0, data0, last0, req1, data1, last1, fifo_full,
    input  ack0, ack1, fifo_wr, fifo_wdata, busy, owner, ovf
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Two-requester frame arbiter for a single FIFO write port: a grant is held
// for a whole frame, with round-robin between frames and a length cap.
module fifo_wr_arb #(
  parameter int B      = 8,
  parameter int MAXLEN = 16
) (
  input  logic          clk,
  input  logic          reset,
  fifo_wr_arb_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(MAXLEN - 1);

  state_t       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         owner_q, owner_d;
  logic         ovf_q, ovf_d;

  logic         wr;
  logic         sel;
  logic         sel_req;
  logic         sel_last;
  logic [B-1:0] wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= 8'd0;
      owner_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    ovf_d    = 1'b0;
    wr       = 1'b0;
    sel      = (state_q == GNT1);
    sel_req  = 1'b0;
    sel_last = 1'b0;
    wdata    = bus.data0;

    case (state_q)
      IDLE: begin
        // Pointer 0 favours requester 0 on contention, pointer 1 requester 1.
        if (bus.req0 && (!bus.req1 || !ptr_q)) begin
          state_d = GNT0;
          owner_d = 1'b0;
          cnt_d   = 8'd0;
        end else if (bus.req1) begin
          state_d = GNT1;
          owner_d = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      GNT0, GNT1: begin
        sel_req  = sel ? bus.req1  : bus.req0;
        sel_last = sel ? bus.last1 : bus.last0;
        wdata    = sel ? bus.data1 : bus.data0;
        wr       = sel_req && !bus.fifo_full;
        if (wr) begin
          cnt_d = cnt_q + 8'd1;
          // A frame ends on its last byte or when it hits the length cap.
          if (sel_last || (cnt_q == CNT_LIMIT)) begin
            state_d = IDLE;
            ptr_d   = ~sel;
            ovf_d   = ~sel_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_wr    = wr;
  assign bus.fifo_wdata = wdata;
  assign bus.ack0       = wr && !sel;
  assign bus.ack1       = wr && sel;
  assign bus.busy       = (state_q != IDLE);
  assign bus.owner      = owner_q;
  assign bus.ovf        = ovf_q;
endmodule
